// File: rtl/data_sram_rsp_pkg.sv
// Shared definitions for the data SRAM responder: size encodings, latency bounds,
// default geometry and the response payload carried through the delay line.
package data_sram_rsp_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam int unsigned LATENCY_MIN    = 1;
  localparam int unsigned LATENCY_MAX    = 4;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic              wr;
    logic [WORD_W-1:0] word;
  } rsp_payload_t;

  // Out-of-range latencies fall back to the nearest legal depth.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/rsp_delay_line.sv
// Fixed-depth response pipeline; every stage advances together when shift_en is high
// and the whole line freezes otherwise.
module rsp_delay_line #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 shift_en,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q [LATENCY];
  logic [PAYLOAD_W-1:0] payload_d [LATENCY];

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (shift_en) begin
      valid_d[0]   = in_valid;
      payload_d[0] = in_payload;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_d[i]   = valid_q[i-1];
        payload_d[i] = payload_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) payload_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q[LATENCY-1];
  assign out_payload = payload_q[LATENCY-1];

endmodule

// File: rtl/data_sram_rsp.sv
// Single-port data SRAM model with a fixed-latency, stallable response path and
// completed load/store counters.
module data_sram_rsp
  import data_sram_rsp_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  input  logic              stall,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned LAT_EFF   = clamp_latency(LATENCY);
  localparam int unsigned PAYLOAD_W = $bits(rsp_payload_t);
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  rsp_payload_t      in_payload, out_payload;
  logic [PAYLOAD_W-1:0] out_payload_raw;
  logic              out_valid;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic              unused_ok;

  // size is informational and the MEM stage does its own lane select.
  assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx     = addr[ADDR_W+1:2];
  assign addr_ok = !stall;
  assign accept  = req && addr_ok;

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Loads read the pre-edge array, so any store accepted earlier is already visible.
  always_comb begin
    in_payload.wr   = wr;
    in_payload.word = wr ? '0 : mem_q[idx];
  end

  rsp_delay_line #(
    .LATENCY   (LAT_EFF),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_delay_line (
    .clk         (clk),
    .resetn      (resetn),
    .shift_en    (!stall),
    .in_valid    (accept),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_payload (out_payload_raw)
  );

  assign out_payload = rsp_payload_t'(out_payload_raw);
  assign data_ok     = out_valid && !stall;
  assign rdata       = (data_ok && !out_payload.wr) ? out_payload.word : 32'h0;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (data_ok) begin
      if (out_payload.wr) wr_cnt_d = wr_cnt_q + 1'b1;
      else                rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_rsp.sv
// Scoreboard bench for data_sram_rsp: a LATENCY=1 and a LATENCY=3 instance share the
// request buses; each has its own req line and expected-response queue.
module tb_data_sram_rsp;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_1 = 1'b0, req_3 = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        stall = 1'b0;

  logic        addr_ok_1, data_ok_1, addr_ok_3, data_ok_3;
  logic [31:0] rdata_1, rdata_3, rd_cnt_1, wr_cnt_1, rd_cnt_3, wr_cnt_3;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  data_sram_rsp #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(req_1), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall(stall), .addr_ok(addr_ok_1),
    .data_ok(data_ok_1), .rdata(rdata_1), .rd_cnt(rd_cnt_1), .wr_cnt(wr_cnt_1)
  );

  data_sram_rsp #(.ADDR_W(6), .LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .req(req_3), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall(stall), .addr_ok(addr_ok_3),
    .data_ok(data_ok_3), .rdata(rdata_3), .rd_cnt(rd_cnt_3), .wr_cnt(wr_cnt_3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the falling edge; the monitor samples 2ns after it.
  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dat, input logic [31:0] exp_rd, input int extra,
                       input bit push);
    exp_t e;
    @(negedge clk); #1;
    req_1 = (d == 1); req_3 = (d == 3);
    wr = w; addr = a; wstrb = s; wdata = dat; stall = 1'b0;
    size = w ? 2'd2 : 2'd2;
    if (push) begin
      e.rdata = exp_rd;
      e.due   = cyc + d + extra;
      if (d == 1) q1.push_back(e); else q3.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      req_1 = 1'b0; req_3 = 1'b0; stall = 1'b0;
    end
  endtask

  task automatic sample_point();
    @(negedge clk); #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (data_ok_1) begin
      nvec++;
      if (q1.size() == 0) begin
        nerr++;
        $display("FAIL lat1_unexpected_rsp: got data_ok rdata %h at cycle %0d, expected none", rdata_1, cyc);
      end else begin
        e = q1.pop_front();
        if (rdata_1 !== e.rdata || cyc != e.due) begin
          nerr++;
          $display("FAIL lat1_rsp: got rdata %h cycle %0d expected rdata %h cycle %0d", rdata_1, cyc, e.rdata, e.due);
        end
      end
    end
    if (data_ok_3) begin
      nvec++;
      if (q3.size() == 0) begin
        nerr++;
        $display("FAIL lat3_unexpected_rsp: got data_ok rdata %h at cycle %0d, expected none", rdata_3, cyc);
      end else begin
        e = q3.pop_front();
        if (rdata_3 !== e.rdata || cyc != e.due) begin
          nerr++;
          $display("FAIL lat3_rsp: got rdata %h cycle %0d expected rdata %h cycle %0d", rdata_3, cyc, e.rdata, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    sample_point();
    check("rst_data_ok_1", {31'b0, data_ok_1}, 32'd0);
    check("rst_data_ok_3", {31'b0, data_ok_3}, 32'd0);
    check("rst_rdata_1", rdata_1, 32'h0);
    check("rst_rd_cnt_1", rd_cnt_1, 32'd0);
    check("rst_wr_cnt_3", wr_cnt_3, 32'd0);
    check("rst_addr_ok_nostall", {31'b0, addr_ok_1}, 32'd1);
    stall = 1'b1;
    sample_point();
    check("rst_addr_ok_stall", {31'b0, addr_ok_3}, 32'd0);
    @(negedge clk); #1;
    stall = 1'b0;
    resetn = 1'b1;

    // LATENCY=1 store then load.
    issue(1, 1'b1, 32'h10, 4'hF, 32'h12345678, 32'h0, 0, 1'b1);
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h12345678, 0, 1'b1);
    idle(1);
    repeat (2) sample_point();
    check("l1_wr_cnt_a", wr_cnt_1, 32'd1);
    check("l1_rd_cnt_a", rd_cnt_1, 32'd1);

    // Byte-lane merge.
    issue(1, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, 32'h0, 0, 1'b1);
    issue(1, 1'b1, 32'h20, 4'b0100, 32'h00EE0000, 32'h0, 0, 1'b1);
    issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hAAEECCDD, 0, 1'b1);
    idle(1);
    repeat (2) sample_point();
    check("l1_wr_cnt_b", wr_cnt_1, 32'd3);
    check("l1_rd_cnt_b", rd_cnt_1, 32'd2);

    // Store with no enabled lanes still completes.
    issue(1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 1'b1);
    issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hAAEECCDD, 0, 1'b1);
    idle(1);
    repeat (2) sample_point();
    check("l1_wr_cnt_c", wr_cnt_1, 32'd4);
    check("l1_rd_cnt_c", rd_cnt_1, 32'd3);

    // LATENCY=3: four stores then four back-to-back loads.
    issue(3, 1'b1, 32'h0, 4'hF, 32'hA0A0A001, 32'h0, 0, 1'b1);
    issue(3, 1'b1, 32'h4, 4'hF, 32'hB0B0B002, 32'h0, 0, 1'b1);
    issue(3, 1'b1, 32'h8, 4'hF, 32'hC0C0C003, 32'h0, 0, 1'b1);
    issue(3, 1'b1, 32'hC, 4'hF, 32'hD0D0D004, 32'h0, 0, 1'b1);
    issue(3, 1'b0, 32'h0, 4'h0, 32'h0, 32'hA0A0A001, 0, 1'b1);
    issue(3, 1'b0, 32'h4, 4'h0, 32'h0, 32'hB0B0B002, 0, 1'b1);
    issue(3, 1'b0, 32'h8, 4'h0, 32'h0, 32'hC0C0C003, 0, 1'b1);
    issue(3, 1'b0, 32'hC, 4'h0, 32'h0, 32'hD0D0D004, 0, 1'b1);
    idle(1);
    repeat (5) sample_point();
    check("l3_wr_cnt_a", wr_cnt_3, 32'd4);
    check("l3_rd_cnt_a", rd_cnt_3, 32'd4);

    // Stall for 5 cycles with two loads in flight.
    issue(3, 1'b0, 32'h0, 4'h0, 32'h0, 32'hA0A0A001, 5, 1'b1);
    issue(3, 1'b0, 32'h4, 4'h0, 32'h0, 32'hB0B0B002, 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      req_3 = 1'b0; stall = 1'b1;
      #1;
      check("stall_addr_ok", {31'b0, addr_ok_3}, 32'd0);
      check("stall_data_ok", {31'b0, data_ok_3}, 32'd0);
    end
    idle(1);
    repeat (5) sample_point();
    check("l3_rd_cnt_stall", rd_cnt_3, 32'd6);
    check("l3_wr_cnt_stall", wr_cnt_3, 32'd4);

    // Reset with two loads in flight discards them.
    issue(3, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 0, 1'b0);
    issue(3, 1'b0, 32'hC, 4'h0, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk); #1;
    req_3 = 1'b0; resetn = 1'b0;
    #1;
    check("midrst_data_ok", {31'b0, data_ok_3}, 32'd0);
    check("midrst_rd_cnt", rd_cnt_3, 32'd0);
    @(negedge clk); #1;
    resetn = 1'b1;
    repeat (6) sample_point();
    check("post_rst_rd_cnt_3", rd_cnt_3, 32'd0);
    check("post_rst_wr_cnt_1", wr_cnt_1, 32'd0);
    issue(3, 1'b0, 32'h8, 4'h0, 32'h0, 32'hC0C0C003, 0, 1'b1);
    issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hAAEECCDD, 0, 1'b1);
    idle(1);
    repeat (5) sample_point();
    check("post_rst_rd_cnt_3b", rd_cnt_3, 32'd1);
    check("post_rst_rd_cnt_1b", rd_cnt_1, 32'd1);

    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
